// File: rtl/key_loader_aor64_if.sv
// Operand handshake bundle for key_loader_aor64: upstream operands in,
// registered operands out to the locked adder.
interface key_loader_aor64_if #(
  parameter int unsigned DATA_W = 32
);
  logic              op_valid_i;
  logic              op_ready_o;
  logic [DATA_W-1:0] add1_i;
  logic [DATA_W-1:0] add2_i;
  logic [DATA_W-1:0] add1_o;
  logic [DATA_W-1:0] add2_o;
  logic              op_valid_o;
  logic              op_ready_i;

  modport slave (
    input  op_valid_i, add1_i, add2_i, op_ready_i,
    output op_ready_o, add1_o, add2_o, op_valid_o
  );

  modport master (
    output op_valid_i, add1_i, add2_i, op_ready_i,
    input  op_ready_o, add1_o, add2_o, op_valid_o
  );
endinterface

// File: rtl/key_loader_aor64.sv
// Serial key loader for a logic-locked adder with a one-deep operand stage.
// Optional macro KEY_PARITY_EN adds a trailing even-parity bit to each load.
module key_loader_aor64 #(
  parameter int unsigned KEY_W  = 64,
  parameter int unsigned DATA_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_start_i,
  input  logic             key_bit_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  output logic [KEY_W-1:0] keyinput_o,
  output logic             key_armed_o,
  output logic             key_err_o,
  key_loader_aor64_if.slave op_if
);

`ifdef KEY_PARITY_EN
  localparam int unsigned LOAD_BITS = KEY_W + 1;
`else
  localparam int unsigned LOAD_BITS = KEY_W;
`endif
  localparam int unsigned CNT_W = $clog2(LOAD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOAD_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_ARMED} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [KEY_W-1:0]  r_shadow;
  logic [KEY_W-1:0]  r_key;
  logic [DATA_W-1:0] r_add1;
  logic [DATA_W-1:0] r_add2;
  logic              r_op_valid;
  logic              w_clear;
  logic              w_accept;
  logic              w_commit;
  logic              w_op_ready;
  logic              w_op_take;
  logic [KEY_W-1:0]  w_bit_mask;
`ifdef KEY_PARITY_EN
  logic              r_have_key;
  logic              r_err;
  logic              w_par_bad;
`endif

  assign w_bit_mask = KEY_W'(key_bit_i) << r_count;

  // A start request always wins over a bit offered in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
`ifdef KEY_PARITY_EN
    w_par_bad   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (key_start_i) begin
          w_state_nxt = S_LOAD;
          w_clear     = 1'b1;
        end
      end
      S_LOAD: begin
        if (key_start_i) begin
          w_clear = 1'b1;
        end else if (key_valid_i) begin
          w_accept = 1'b1;
          if (r_count == LAST) begin
`ifdef KEY_PARITY_EN
            if ((^r_shadow) != key_bit_i) begin
              w_par_bad   = 1'b1;
              w_state_nxt = r_have_key ? S_ARMED : S_IDLE;
            end else begin
              w_state_nxt = S_COMMIT;
            end
`else
            w_state_nxt = S_COMMIT;
`endif
          end
        end
      end
      S_COMMIT: begin
        if (key_start_i) begin
          w_state_nxt = S_LOAD;
          w_clear     = 1'b1;
        end else if (!r_op_valid) begin
          w_commit    = 1'b1;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (key_start_i) begin
          w_state_nxt = S_LOAD;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_op_ready = (r_state == S_ARMED) && (!r_op_valid || op_if.op_ready_i);
  assign w_op_take  = op_if.op_valid_i && w_op_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_shadow   <= '0;
      r_key      <= '0;
      r_add1     <= '0;
      r_add2     <= '0;
      r_op_valid <= 1'b0;
`ifdef KEY_PARITY_EN
      r_have_key <= 1'b0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;

      if (w_clear) begin
        r_count  <= '0;
        r_shadow <= '0;
      end else if (w_accept) begin
        r_count  <= r_count + CNT_W'(1);
        r_shadow <= r_shadow | w_bit_mask;
      end
`ifdef KEY_PARITY_EN
      if (w_par_bad) begin
        r_count  <= '0;
        r_shadow <= '0;
      end
      r_err <= w_par_bad;
      if (w_commit) r_have_key <= 1'b1;
`endif

      // The key only moves here, and only with the operand stage empty.
      if (w_commit) r_key <= r_shadow;

      if (w_op_take) begin
        r_add1     <= op_if.add1_i;
        r_add2     <= op_if.add2_i;
        r_op_valid <= 1'b1;
      end else if (op_if.op_ready_i) begin
        r_op_valid <= 1'b0;
      end
    end
  end

  assign key_ready_o       = (r_state == S_LOAD);
  assign key_armed_o       = (r_state == S_ARMED);
  assign keyinput_o        = r_key;
`ifdef KEY_PARITY_EN
  assign key_err_o         = r_err;
`else
  assign key_err_o         = 1'b0;
`endif
  assign op_if.op_ready_o  = w_op_ready;
  assign op_if.op_valid_o  = r_op_valid;
  assign op_if.add1_o      = r_add1;
  assign op_if.add2_o      = r_add2;

endmodule

// File: tb/tb_key_loader_aor64.sv
// Directed self-checking bench for key_loader_aor64 (honours KEY_PARITY_EN).
module tb_key_loader_aor64;
  localparam int unsigned KEY_W  = 64;
  localparam int unsigned DATA_W = 32;

  localparam logic [63:0] KEY1 = 64'hA5A5_0F0F_1234_FFFF;
  localparam logic [63:0] KEY2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] KEY3 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] KEY4 = 64'h0F1E_2D3C_4B5A_6978;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             key_start_i;
  logic             key_bit_i;
  logic             key_valid_i;
  logic             key_ready_o;
  logic [KEY_W-1:0] keyinput_o;
  logic             key_armed_o;
  logic             key_err_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  key_loader_aor64_if #(.DATA_W(DATA_W)) op_if ();

  key_loader_aor64 #(.KEY_W(KEY_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .key_start_i (key_start_i),
    .key_bit_i   (key_bit_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .keyinput_o  (keyinput_o),
    .key_armed_o (key_armed_o),
    .key_err_o   (key_err_o),
    .op_if       (op_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    key_start_i = 1'b1;
    tick();
    key_start_i = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] k, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      key_bit_i   = k[i];
      key_valid_i = 1'b1;
      tick();
    end
    key_valid_i = 1'b0;
    key_bit_i   = 1'b0;
  endtask

  task automatic load_key(input logic [63:0] k);
    start_load();
    send_bits(k, 64);
`ifdef KEY_PARITY_EN
    send_bits({63'd0, ^k}, 1);
`endif
  endtask

  task automatic wait_armed(input string tag, input logic [63:0] exp);
    for (int i = 0; i < 8 && !key_armed_o; i++) tick();
    chk({tag, "_armed"}, {63'd0, key_armed_o}, 64'd1);
    chk({tag, "_key"}, keyinput_o, exp);
  endtask

  initial begin
    rst_i = 1'b1; key_start_i = 1'b0; key_bit_i = 1'b0; key_valid_i = 1'b0;
    op_if.op_valid_i = 1'b0; op_if.op_ready_i = 1'b0;
    op_if.add1_i = '0; op_if.add2_i = '0;
    tick(); tick();

    chk("rst_key",    keyinput_o, 64'd0);
    chk("rst_armed",  {63'd0, key_armed_o}, 64'd0);
    chk("rst_ready",  {63'd0, key_ready_o}, 64'd0);
    chk("rst_err",    {63'd0, key_err_o}, 64'd0);
    chk("rst_ovalid", {63'd0, op_if.op_valid_o}, 64'd0);
    chk("rst_oready", {63'd0, op_if.op_ready_o}, 64'd0);
    chk("rst_add1",   {32'd0, op_if.add1_o}, 64'd0);
    rst_i = 1'b0;
    tick();

    // First key load
    start_load();
    chk("load_ready", {63'd0, key_ready_o}, 64'd1);
    send_bits(KEY1, 63);
    chk("key_before_last", keyinput_o, 64'd0);
    send_bits(KEY1 >> 63, 1);
    chk("key_after_last", keyinput_o, 64'd0);
`ifdef KEY_PARITY_EN
    send_bits({63'd0, ^KEY1}, 1);
`endif
    wait_armed("key1", KEY1);

    // Back-to-back operands
    op_if.op_ready_i = 1'b1;
    op_if.op_valid_i = 1'b1;
    op_if.add1_i = 32'hFFFF_FFFF; op_if.add2_i = 32'h1;
    chk("b2b_oready0", {63'd0, op_if.op_ready_o}, 64'd1);
    tick();
    chk("b2b_valid0", {63'd0, op_if.op_valid_o}, 64'd1);
    chk("b2b_add1_0", {32'd0, op_if.add1_o}, 64'hFFFF_FFFF);
    chk("b2b_add2_0", {32'd0, op_if.add2_o}, 64'd1);
    op_if.add1_i = 32'd5; op_if.add2_i = 32'd7;
    chk("b2b_oready1", {63'd0, op_if.op_ready_o}, 64'd1);
    tick();
    op_if.op_valid_i = 1'b0;
    chk("b2b_valid1", {63'd0, op_if.op_valid_o}, 64'd1);
    chk("b2b_add1_1", {32'd0, op_if.add1_o}, 64'd5);
    chk("b2b_add2_1", {32'd0, op_if.add2_o}, 64'd7);
    tick();
    chk("b2b_drain", {63'd0, op_if.op_valid_o}, 64'd0);

    // Stalled operand blocks a key commit
    op_if.op_ready_i = 1'b0;
    op_if.op_valid_i = 1'b1;
    op_if.add1_i = 32'd3; op_if.add2_i = 32'd4;
    tick();
    op_if.op_valid_i = 1'b0;
    op_if.add1_i = 32'd9; op_if.add2_i = 32'd9;
    tick();
    chk("stall_valid", {63'd0, op_if.op_valid_o}, 64'd1);
    chk("stall_add1",  {32'd0, op_if.add1_o}, 64'd3);
    chk("stall_add2",  {32'd0, op_if.add2_o}, 64'd4);
    chk("stall_oready", {63'd0, op_if.op_ready_o}, 64'd0);
    load_key(KEY2);
    tick(); tick(); tick();
    chk("stall_oldkey", keyinput_o, KEY1);
    chk("stall_armed",  {63'd0, key_armed_o}, 64'd0);
    chk("stall_hold",   {32'd0, op_if.add1_o}, 64'd3);
    op_if.op_ready_i = 1'b1;
    tick();
    chk("drain_valid",  {63'd0, op_if.op_valid_o}, 64'd0);
    chk("drain_oldkey", keyinput_o, KEY1);
    tick();
    chk("commit_key",   keyinput_o, KEY2);
    chk("commit_armed", {63'd0, key_armed_o}, 64'd1);

    // Reset mid-load
    start_load();
    send_bits(KEY3, 20);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_key",   keyinput_o, 64'd0);
    chk("midrst_armed", {63'd0, key_armed_o}, 64'd0);
    chk("midrst_ready", {63'd0, key_ready_o}, 64'd0);
    tick();
    load_key(KEY3);
    wait_armed("key3", KEY3);

    // Restart after 40 bits
    start_load();
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 40);
    chk("restart_armed", {63'd0, key_armed_o}, 64'd0);
    load_key(KEY4);
    wait_armed("key4", KEY4);

`ifdef KEY_PARITY_EN
    start_load();
    send_bits(64'h1, 64);
    send_bits(64'h0, 1);
    chk("par_err",   {63'd0, key_err_o}, 64'd1);
    chk("par_key",   keyinput_o, KEY4);
    chk("par_armed", {63'd0, key_armed_o}, 64'd1);
    tick();
    chk("par_err_clr", {63'd0, key_err_o}, 64'd0);
    start_load();
    send_bits(64'h1, 64);
    send_bits(64'h1, 1);
    chk("par_ok_err", {63'd0, key_err_o}, 64'd0);
    wait_armed("par_ok", 64'h1);
`else
    chk("err_tied", {63'd0, key_err_o}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
